// File: rtl/aq_djpeg_pkg.sv
// ---------------------------------------------------------------------------
// aq_djpeg_pkg
//  Shared definitions for the JPEG DHT loader: FSM state encoding, the
//  two-bit table colour encoding and default table RAM depths.
// ---------------------------------------------------------------------------
package aq_djpeg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_TCTH,
      ST_COUNTS,
      ST_SYMBOLS,
      ST_SKIP,
      ST_DONE
   } state_t;

   // {Th != 0, Tc[0]}
   typedef logic [1:0] color_t;

   localparam color_t COLOR_YDC = 2'b00;
   localparam color_t COLOR_YAC = 2'b01;
   localparam color_t COLOR_CDC = 2'b10;
   localparam color_t COLOR_CAC = 2'b11;

   localparam int DC_DEPTH_DEFAULT = 16;
   localparam int AC_DEPTH_DEFAULT = 256;

   // Map a Tc/Th byte (Tc in [7:4], Th in [3:0]) onto the table colour.
   function automatic color_t color_of(input logic [7:0] tcth);
      return {tcth[3:0] != 4'd0, tcth[4]};
   endfunction

endpackage

// File: rtl/aq_djpeg_dht_loader_if.sv
// ---------------------------------------------------------------------------
// aq_djpeg_dht_loader_if
//  Byte-stream input and table-write outputs of the DHT loader.
//   master : header parser side (drives Start/DataValid/DataByte)
//   slave  : the loader (drives handshake status and write strobes)
// ---------------------------------------------------------------------------
interface aq_djpeg_dht_loader_if;
   import aq_djpeg_pkg::*;

   logic         Start;
   logic         DataValid;
   logic [7:0]   DataByte;
   logic         DataReady;
   logic         Busy;
   logic         Done;
   logic         Error;
   logic         DhtWrEnable;
   color_t       DhtWrColor;
   logic [7:0]   DhtWrCount;
   logic [7:0]   DhtWrData;
   logic         CodeWrEnable;
   color_t       CodeWrColor;
   logic [3:0]   CodeWrLength;
   logic [15:0]  CodeWrCode;
   logic [7:0]   CodeWrStart;

   modport master (
      output Start, DataValid, DataByte,
      input  DataReady, Busy, Done, Error,
      input  DhtWrEnable, DhtWrColor, DhtWrCount, DhtWrData,
      input  CodeWrEnable, CodeWrColor, CodeWrLength, CodeWrCode, CodeWrStart
   );

   modport slave (
      input  Start, DataValid, DataByte,
      output DataReady, Busy, Done, Error,
      output DhtWrEnable, DhtWrColor, DhtWrCount, DhtWrData,
      output CodeWrEnable, CodeWrColor, CodeWrLength, CodeWrCode, CodeWrStart
   );

endinterface

// File: rtl/aq_djpeg_dht_codegen.sv
// ---------------------------------------------------------------------------
// aq_djpeg_dht_codegen
//  Canonical Huffman code generator. For every code-length count byte it
//  emits the first code of that length and the symbol index it maps to,
//  then advances the running code and symbol total.
//  Ports:
//   clk, rst          clock, synchronous active-high reset
//   clear_i           restart accumulation for a new table
//   step_i, len_i     consume one count byte L (len_idx_i = length-1)
//   color_i           colour of the current table
//   sym_total_o       symbols counted so far (9 bits)
//   code_wr_*_o       registered code-table write (1-cycle strobe)
// ---------------------------------------------------------------------------
module aq_djpeg_dht_codegen
   import aq_djpeg_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear_i,
   input  logic        step_i,
   input  logic [7:0]  len_i,
   input  logic [3:0]  len_idx_i,
   input  color_t      color_i,
   output logic [8:0]  sym_total_o,
   output logic        code_wr_enable_o,
   output color_t      code_wr_color_o,
   output logic [3:0]  code_wr_length_o,
   output logic [15:0] code_wr_code_o,
   output logic [7:0]  code_wr_start_o
);

   logic [15:0] code_acc_q, code_acc_d;
   logic [8:0]  sym_total_q, sym_total_d;
   logic        wr_en_q;
   color_t      wr_color_q;
   logic [3:0]  wr_length_q;
   logic [15:0] wr_code_q;
   logic [7:0]  wr_start_q;

   // NOTE: every variable gets a default before any branch so the block can
   // never hold a value between evaluations (no latch).
   always_comb begin
      code_acc_d  = code_acc_q;
      sym_total_d = sym_total_q;
      if (clear_i) begin
         code_acc_d  = '0;
         sym_total_d = '0;
      end else if (step_i) begin
         // Next length starts one bit longer, after the L codes of this one.
         code_acc_d  = (code_acc_q + {8'd0, len_i}) << 1;
         sym_total_d = sym_total_q + {1'b0, len_i};
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         code_acc_q  <= '0;
         sym_total_q <= '0;
         wr_en_q     <= 1'b0;
         wr_color_q  <= '0;
         wr_length_q <= '0;
         wr_code_q   <= '0;
         wr_start_q  <= '0;
      end else begin
         code_acc_q  <= code_acc_d;
         sym_total_q <= sym_total_d;
         wr_en_q     <= step_i;
         if (step_i) begin
            wr_color_q  <= color_i;
            wr_length_q <= len_idx_i;
            wr_code_q   <= code_acc_q;
            wr_start_q  <= sym_total_q[7:0];
         end
      end
   end

   assign sym_total_o      = sym_total_q;
   assign code_wr_enable_o = wr_en_q;
   assign code_wr_color_o  = wr_color_q;
   assign code_wr_length_o = wr_length_q;
   assign code_wr_code_o   = wr_code_q;
   assign code_wr_start_o  = wr_start_q;

endmodule

// File: rtl/aq_djpeg_dht_loader.sv
// ---------------------------------------------------------------------------
// aq_djpeg_dht_loader
//  Parses a JPEG DHT segment payload (bytes following FFC4) and sequences
//  symbol writes into the Huffman table RAMs plus per-length canonical
//  min-code/start-index writes. Several tables per segment are accepted.
//  Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        aq_djpeg_dht_loader_if.slave: Start/DataValid/DataByte in;
//              DataReady, Busy, Done, Error, DhtWr*, CodeWr* out
//  Parameters: DC_DEPTH / AC_DEPTH - maximum symbols per DC / AC table.
//  Option: define AQ_DJPEG_DHT_CHECK_EN to enable range/truncation checks
//  driving Error; otherwise Error is tied low.
// ---------------------------------------------------------------------------
module aq_djpeg_dht_loader
   import aq_djpeg_pkg::*;
#(
   parameter int DC_DEPTH = DC_DEPTH_DEFAULT,
   parameter int AC_DEPTH = AC_DEPTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   aq_djpeg_dht_loader_if.slave   bus
);

`ifdef AQ_DJPEG_DHT_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   localparam logic [8:0] DC_LIMIT = 9'(DC_DEPTH);
   localparam logic [8:0] AC_LIMIT = 9'(AC_DEPTH);

   state_t      state_q, state_d;
   logic [15:0] rem_q, rem_d;
   logic [7:0]  len_hi_q, len_hi_d;
   color_t      color_q, color_d;
   logic [3:0]  len_idx_q, len_idx_d;
   logic [8:0]  sym_idx_q, sym_idx_d;

   logic        data_ready;
   logic        accept;
   logic        err_set;
   logic        cg_clear;
   logic        cg_step;
   logic        dht_wr;
   logic [8:0]  sym_total;
   logic [8:0]  total_new;
   logic [15:0] rem_dec;
   logic [15:0] lh;
   logic        bad_tcth;
   logic        oversize;

   logic        dht_en_q;
   color_t      dht_color_q;
   logic [7:0]  dht_count_q;
   logic [7:0]  dht_data_q;

   // Start pre-empts any accept so the byte presented with it stays pending.
   assign data_ready = !bus.Start &&
                       (state_q inside {ST_LEN_HI, ST_LEN_LO, ST_TCTH,
                                        ST_COUNTS, ST_SYMBOLS, ST_SKIP});
   assign accept     = bus.DataValid && data_ready;
   assign rem_dec    = rem_q - 16'd1;
   assign lh         = {len_hi_q, bus.DataByte};
   assign total_new  = sym_total + {1'b0, bus.DataByte};
   assign bad_tcth   = CHECK_EN && (bus.DataByte[7:4] > 4'd1 || bus.DataByte[3:0] > 4'd1);
   assign oversize   = CHECK_EN &&
                       (color_q[0] ? (total_new > AC_LIMIT) : (total_new > DC_LIMIT));

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      len_hi_d  = len_hi_q;
      color_d   = color_q;
      len_idx_d = len_idx_q;
      sym_idx_d = sym_idx_q;
      err_set   = 1'b0;
      cg_clear  = 1'b0;
      cg_step   = 1'b0;
      dht_wr    = 1'b0;

      if (bus.Start) begin
         state_d = ST_LEN_HI;
      end else begin
         unique case (state_q)
            ST_IDLE: ;
            ST_LEN_HI: if (accept) begin
               len_hi_d = bus.DataByte;
               state_d  = ST_LEN_LO;
            end
            ST_LEN_LO: if (accept) begin
               if (lh < 16'd2) begin
                  rem_d   = '0;
                  err_set = CHECK_EN;
                  state_d = ST_DONE;
               end else begin
                  rem_d   = lh - 16'd2;
                  state_d = (lh == 16'd2) ? ST_DONE : ST_TCTH;
               end
            end
            ST_TCTH: if (accept) begin
               rem_d     = rem_dec;
               color_d   = color_of(bus.DataByte);
               cg_clear  = 1'b1;
               len_idx_d = '0;
               sym_idx_d = '0;
               if (bad_tcth) begin
                  err_set = 1'b1;
                  state_d = (rem_dec == '0) ? ST_DONE : ST_SKIP;
               end else if (rem_dec == '0) begin
                  err_set = CHECK_EN;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_COUNTS;
               end
            end
            ST_COUNTS: if (accept) begin
               rem_d     = rem_dec;
               cg_step   = 1'b1;
               len_idx_d = len_idx_q + 4'd1;
               if (len_idx_q == 4'd15) begin
                  if (oversize) begin
                     err_set = 1'b1;
                     state_d = (rem_dec == '0) ? ST_DONE : ST_SKIP;
                  end else if (total_new == '0) begin
                     // Empty table: nothing to write, go straight to table end.
                     state_d = (rem_dec == '0) ? ST_DONE : ST_TCTH;
                  end else if (rem_dec == '0) begin
                     err_set = CHECK_EN;
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_SYMBOLS;
                  end
               end else if (rem_dec == '0) begin
                  err_set = CHECK_EN;
                  state_d = ST_DONE;
               end
            end
            ST_SYMBOLS: if (accept) begin
               rem_d     = rem_dec;
               dht_wr    = 1'b1;
               sym_idx_d = sym_idx_q + 9'd1;
               if (sym_idx_q + 9'd1 == sym_total) begin
                  state_d = (rem_dec == '0) ? ST_DONE : ST_TCTH;
               end else if (rem_dec == '0) begin
                  err_set = CHECK_EN;
                  state_d = ST_DONE;
               end
            end
            ST_SKIP: if (accept) begin
               rem_d = rem_dec;
               if (rem_dec == '0) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rem_q       <= '0;
         len_hi_q    <= '0;
         color_q     <= '0;
         len_idx_q   <= '0;
         sym_idx_q   <= '0;
         dht_en_q    <= 1'b0;
         dht_color_q <= '0;
         dht_count_q <= '0;
         dht_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         len_hi_q  <= len_hi_d;
         color_q   <= color_d;
         len_idx_q <= len_idx_d;
         sym_idx_q <= sym_idx_d;
         dht_en_q  <= dht_wr;
         if (dht_wr) begin
            dht_color_q <= color_q;
            dht_count_q <= sym_idx_q[7:0];
            dht_data_q  <= bus.DataByte;
         end
      end
   end

`ifdef AQ_DJPEG_DHT_CHECK_EN
   logic error_q;

   always_ff @(posedge clk) begin
      if (rst || bus.Start) error_q <= 1'b0;
      else if (err_set)     error_q <= 1'b1;
   end

   assign bus.Error = error_q;
`else
   // Without checks nothing observes err_set; keep it visibly consumed.
   logic unused_err_set;
   assign unused_err_set = err_set;
   assign bus.Error      = 1'b0;
`endif

   logic        cw_en;
   color_t      cw_color;
   logic [3:0]  cw_length;
   logic [15:0] cw_code;
   logic [7:0]  cw_start;

   aq_djpeg_dht_codegen u_codegen (
      .clk              (clk),
      .rst              (rst || bus.Start),
      .clear_i          (cg_clear),
      .step_i           (cg_step),
      .len_i            (bus.DataByte),
      .len_idx_i        (len_idx_q),
      .color_i          (color_q),
      .sym_total_o      (sym_total),
      .code_wr_enable_o (cw_en),
      .code_wr_color_o  (cw_color),
      .code_wr_length_o (cw_length),
      .code_wr_code_o   (cw_code),
      .code_wr_start_o  (cw_start)
   );

   assign bus.DataReady    = data_ready;
   assign bus.Busy         = (state_q != ST_IDLE);
   assign bus.Done         = (state_q == ST_DONE);
   assign bus.DhtWrEnable  = dht_en_q;
   assign bus.DhtWrColor   = dht_color_q;
   assign bus.DhtWrCount   = dht_count_q;
   assign bus.DhtWrData    = dht_data_q;
   assign bus.CodeWrEnable = cw_en;
   assign bus.CodeWrColor  = cw_color;
   assign bus.CodeWrLength = cw_length;
   assign bus.CodeWrCode   = cw_code;
   assign bus.CodeWrStart  = cw_start;

endmodule

// File: tb/tb_aq_djpeg_dht_loader.sv
// ---------------------------------------------------------------------------
// tb_aq_djpeg_dht_loader
//  Self-checking bench for aq_djpeg_dht_loader. Segments are built as byte
//  queues; a reference parser walks the same bytes and predicts the code
//  and symbol writes, Error and a single Done per completed segment.
// ---------------------------------------------------------------------------
module tb_aq_djpeg_dht_loader;
   import aq_djpeg_pkg::*;

   typedef logic [7:0] bq_t[$];

`ifdef AQ_DJPEG_DHT_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aq_djpeg_dht_loader_if bus ();

   aq_djpeg_dht_loader #(.DC_DEPTH(16), .AC_DEPTH(256)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] got_code[$], got_dht[$], exp_code[$], exp_dht[$];
   logic        exp_err;
   int          done_cnt  = 0;
   int          done_base = 0;
   int          both_cnt  = 0;
   bq_t         body;

   // Capture every strobe half a cycle away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.DhtWrEnable)
            got_dht.push_back({14'd0, bus.DhtWrColor, bus.DhtWrCount, bus.DhtWrData});
         if (bus.CodeWrEnable)
            got_code.push_back({2'd0, bus.CodeWrColor, bus.CodeWrLength,
                                bus.CodeWrCode, bus.CodeWrStart});
         if (bus.DhtWrEnable && bus.CodeWrEnable) both_cnt++;
         if (bus.Done) done_cnt++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] all_outputs();
      return {10'd0, bus.DataReady, bus.Busy, bus.Done, bus.Error,
              bus.DhtWrEnable, bus.DhtWrColor, bus.DhtWrCount, bus.DhtWrData,
              bus.CodeWrEnable, bus.CodeWrColor, bus.CodeWrLength,
              bus.CodeWrCode, bus.CodeWrStart};
   endfunction

   // Reference parser: walks the segment the way a software JPEG decoder
   // would, producing the expected write lists and error flag.
   task automatic model(input bq_t seg);
      int rem, pos, lh, start, total, tc, th, len;
      logic [15:0] code;
      logic [1:0]  col;
      logic [7:0]  b;
      bit          fin;
      exp_code.delete();
      exp_dht.delete();
      exp_err = 1'b0;
      lh  = int'({seg[0], seg[1]});
      pos = 2;
      fin = 0;
      if (lh < 2) begin
         rem = 0;
         exp_err = CHK;
      end else rem = lh - 2;
      while (rem > 0 && !fin) begin
         b = seg[pos]; pos++; rem--;
         tc  = int'(b) / 16;
         th  = int'(b) % 16;
         col = {th != 0, tc % 2 == 1};
         if (CHK && (tc > 1 || th > 1)) begin
            exp_err = 1'b1; fin = 1;
         end else if (rem == 0) begin
            exp_err = CHK; fin = 1;
         end else begin
            code  = 16'd0;
            start = 0;
            for (int i = 0; i < 16 && !fin; i++) begin
               len = int'(seg[pos]); pos++; rem--;
               exp_code.push_back({2'd0, col, 4'(i), code, 8'(start)});
               code  = 16'((int'(code) + len) * 2);
               start = start + len;
               if (rem == 0 && i < 15) begin
                  exp_err = CHK; fin = 1;
               end
            end
            if (!fin) begin
               total = start % 512;
               if (CHK && total > ((col[0]) ? 256 : 16)) begin
                  exp_err = 1'b1; fin = 1;
               end else if (total > 0 && rem == 0) begin
                  exp_err = CHK; fin = 1;
               end else begin
                  for (int k = 0; k < total && !fin; k++) begin
                     b = seg[pos]; pos++; rem--;
                     exp_dht.push_back({14'd0, col, 8'(k), b});
                     if (rem == 0 && k < total - 1) begin
                        exp_err = CHK; fin = 1;
                     end
                  end
               end
            end
         end
      end
   endtask

   // Table builders append to 'body'; make_seg prepends Lh.
   task automatic add_fixed_table(input logic [7:0] tcth);
      int counts[16] = '{0, 1, 5, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
      body.push_back(tcth);
      for (int i = 0; i < 16; i++) body.push_back(8'(counts[i]));
      for (int i = 0; i < 12; i++) body.push_back(8'(i));
   endtask

   task automatic add_random_table(input logic [7:0] tcth, input int maxsum);
      int total = 0;
      int l;
      body.push_back(tcth);
      for (int i = 0; i < 16; i++) begin
         l = $urandom_range(0, 3);
         if (total + l > maxsum) l = 0;
         total += l;
         body.push_back(8'(l));
      end
      for (int i = 0; i < total; i++) body.push_back(8'($urandom_range(0, 255)));
   endtask

   function automatic bq_t make_seg(input int lh);
      bq_t s;
      s.push_back(8'(lh / 256));
      s.push_back(8'(lh % 256));
      for (int i = 0; i < lh - 2 && i < body.size(); i++) s.push_back(body[i]);
      return s;
   endfunction

   // mode 0: DataValid always high; 1: toggles every cycle; 2: random gaps.
   task automatic run_seg(input string tag, input bq_t seg, input int mode,
                          input int nbytes, input bit wait_done);
      int idx   = 0;
      int guard = 0;
      bit tog   = 1'b0;
      got_code.delete();
      got_dht.delete();
      both_cnt  = 0;
      done_base = done_cnt;
      @(negedge clk);
      bus.Start     = 1'b1;
      bus.DataValid = 1'b1;
      bus.DataByte  = seg[0];
      @(negedge clk);
      bus.Start = 1'b0;
      check({tag, " busy"}, 64'(bus.Busy), 64'd1);
      while (idx < nbytes && guard < 300) begin
         tog = ~tog;
         bus.DataByte  = seg[idx];
         bus.DataValid = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 2) != 0);
         #1;
         if (bus.DataValid && bus.DataReady) idx++;
         else guard++;
         @(negedge clk);
      end
      bus.DataValid = 1'b0;
      check({tag, " bytes accepted"}, 64'(idx), 64'(nbytes));
      if (wait_done) begin
         for (int c = 0; c < 40 && done_cnt == done_base; c++) @(negedge clk);
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic verify(input string tag, input bq_t seg);
      int n;
      model(seg);
      check({tag, " code count"}, 64'(got_code.size()), 64'(exp_code.size()));
      n = (got_code.size() < exp_code.size()) ? got_code.size() : exp_code.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s code[%0d]", tag, i), 64'(got_code[i]), 64'(exp_code[i]));
      check({tag, " dht count"}, 64'(got_dht.size()), 64'(exp_dht.size()));
      n = (got_dht.size() < exp_dht.size()) ? got_dht.size() : exp_dht.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s dht[%0d]", tag, i), 64'(got_dht[i]), 64'(exp_dht[i]));
      check({tag, " error"}, 64'(bus.Error), 64'(exp_err));
      check({tag, " done pulses"}, 64'(done_cnt - done_base), 64'd1);
      check({tag, " one strobe per cycle"}, 64'(both_cnt), 64'd0);
      check({tag, " idle busy"}, 64'(bus.Busy), 64'd0);
   endtask

   initial begin
      bq_t seg;
      int  nt, cut;
      logic [7:0] tcth;

      rst = 1'b1;
      bus.Start     = 1'b0;
      bus.DataValid = 1'b0;
      bus.DataByte  = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset outputs", all_outputs(), 64'd0);
      rst = 1'b0;

      // 1) single luminance DC table, 12 symbols.
      body.delete();
      add_fixed_table(8'h00);
      seg = make_seg(body.size() + 2);
      run_seg("t1", seg, 0, seg.size(), 1);
      verify("t1", seg);
      if (got_code.size() > 8) begin
         check("t1 code len3", 64'(got_code[2][23:8]), 64'd2);
         check("t1 code len4", 64'(got_code[3][23:8]), 64'd14);
         check("t1 code len9", 64'(got_code[8][23:8]), 64'd510);
      end

      // 2) Ydc followed by Cac in one segment.
      body.delete();
      add_fixed_table(8'h00);
      add_random_table(8'h11, 40);
      seg = make_seg(body.size() + 2);
      run_seg("t2", seg, 0, seg.size(), 1);
      verify("t2", seg);

      // 3) table 1 with DataValid toggling every cycle.
      body.delete();
      add_fixed_table(8'h00);
      seg = make_seg(body.size() + 2);
      run_seg("t3", seg, 1, seg.size(), 1);
      verify("t3", seg);

      // 4) abort during SYMBOLS, then a fresh DC segment.
      run_seg("t4a", seg, 0, 25, 0);
      repeat (3) @(negedge clk);
      check("t4 no done on abort", 64'(done_cnt - done_base), 64'd0);
      check("t4 still busy", 64'(bus.Busy), 64'd1);
      body.delete();
      add_random_table(8'h00, 12);
      seg = make_seg(body.size() + 2);
      run_seg("t4b", seg, 2, seg.size(), 1);
      verify("t4b", seg);

      // 5) DC table with 17 symbols.
      body.delete();
      body.push_back(8'h00);
      for (int i = 0; i < 16; i++) body.push_back((i >= 1 && i <= 6) ? ((i == 1) ? 8'd2 : 8'd3) : 8'd0);
      for (int i = 0; i < 17; i++) body.push_back(8'(100 + i));
      seg = make_seg(body.size() + 2);
      run_seg("t5", seg, 0, seg.size(), 1);
      verify("t5", seg);

      // 6) segment length ends 3 bytes into SYMBOLS.
      body.delete();
      add_fixed_table(8'h00);
      seg = make_seg(2 + 1 + 16 + 3);
      run_seg("t6", seg, 0, seg.size(), 1);
      verify("t6", seg);

      // 7) Lh < 2 and Lh == 2.
      body.delete();
      seg = make_seg(1);
      seg[1] = 8'd1;
      run_seg("t7a", seg, 0, 2, 1);
      verify("t7a", seg);
      seg = make_seg(2);
      run_seg("t7b", seg, 0, 2, 1);
      verify("t7b", seg);

      // 8) Tc out of range.
      body.delete();
      add_random_table(8'h21, 10);
      seg = make_seg(body.size() + 2);
      run_seg("t8", seg, 0, seg.size(), 1);
      verify("t8", seg);

      // 9) reset in the middle of a segment.
      body.delete();
      add_fixed_table(8'h10);
      seg = make_seg(body.size() + 2);
      run_seg("t9a", seg, 0, 22, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t9 reset mid-segment", all_outputs(), 64'd0);
      rst = 1'b0;

      // 10) random multi-table segments, some truncated.
      for (int r = 0; r < 8; r++) begin
         body.delete();
         nt = $urandom_range(1, 3);
         for (int t = 0; t < nt; t++) begin
            tcth = {3'd0, 1'($urandom_range(0, 1)), 3'd0, 1'($urandom_range(0, 1))};
            add_random_table(tcth, tcth[4] ? 40 : 12);
         end
         seg = make_seg(body.size() + 2);
         if ($urandom_range(0, 3) == 0) begin
            cut = $urandom_range(1, body.size() - 1);
            seg = make_seg(cut + 2);
         end
         run_seg($sformatf("rnd%0d", r), seg, $urandom_range(0, 2), seg.size(), 1);
         verify($sformatf("rnd%0d", r), seg);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
